// File: rtl/sound_sequencer.sv
// Note queue and millisecond timer feeding the buzzer generator: buffers {max_count, duration}
// notes, plays them back-to-back and latches silence when the queue drains or is flushed.
module sound_sequencer #(
  parameter int CLK_HZ     = 50000000,
  parameter int FIFO_DEPTH = 8,
  parameter int DUR_W      = 16
) (
  input  logic                            clk,
  input  logic                            rst_async,
  input  logic [25:0]                     note_max_count,
  input  logic [DUR_W-1:0]                note_duration_ms,
  input  logic                            note_push,
  input  logic                            flush,
  output logic                            note_full,
  output logic [$clog2(FIFO_DEPTH):0]     note_count,
  output logic                            playing,
  output logic [25:0]                     max_count,
  output logic                            latch_max_count
);

  localparam int TICKS = CLK_HZ / 1000;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int PRE_W = (TICKS > 1) ? $clog2(TICKS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, SILENCE} state_t;

  typedef struct packed {
    logic [25:0]      max_count;
    logic [DUR_W-1:0] duration;
  } note_t;

  note_t            mem [FIFO_DEPTH];
  note_t            head;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  state_t           state_q, state_d;
  logic [PRE_W-1:0] prescaler_q, prescaler_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [25:0]      max_count_q, max_count_d;
  logic             latch_q, latch_d;
  logic             playing_q, playing_d;
  logic             pop, push_ok, full;

  assign head = mem[rd_ptr_q];
  assign full = (count_q == CNT_W'(FIFO_DEPTH));

  always_comb begin
    // NOTE: every _d signal gets a default before the case so no path can infer a latch.
    state_d     = state_q;
    prescaler_d = prescaler_q;
    dur_d       = dur_q;
    max_count_d = max_count_q;
    latch_d     = 1'b0;

    // A full queue still accepts a push in the cycle it pops its head.
    pop      = (state_q == LOAD) && !flush;
    push_ok  = note_push && !flush && (!full || pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop);

    case (state_q)
      IDLE: begin
        if (count_q != '0) state_d = LOAD;
      end
      LOAD: begin
        if (head.duration != '0) begin
          max_count_d = head.max_count;
          latch_d     = 1'b1;
          dur_d       = head.duration;
          prescaler_d = '0;
          state_d     = PLAY;
        end else begin
          state_d = (count_d != '0) ? LOAD : SILENCE;
        end
      end
      PLAY: begin
        if (prescaler_q == PRE_W'(TICKS - 1)) begin
          prescaler_d = '0;
          dur_d       = dur_q - DUR_W'(1);
          if (dur_q == DUR_W'(1)) state_d = (count_q != '0) ? LOAD : SILENCE;
        end else begin
          prescaler_d = prescaler_q + PRE_W'(1);
        end
      end
      SILENCE: begin
        max_count_d = '0;
        latch_d     = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Flush overrides everything: empty the queue and let SILENCE emit the zero latch.
    if (flush) begin
      state_d     = SILENCE;
      max_count_d = max_count_q;
      latch_d     = 1'b0;
      dur_d       = '0;
      prescaler_d = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
    end

    playing_d = (state_d == LOAD) || (state_d == PLAY);
  end

  // NOTE: the note storage has no reset; entries are only read once count_q says they were written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= '{max_count: note_max_count, duration: note_duration_ms};
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      prescaler_q <= '0;
      dur_q       <= '0;
      max_count_q <= '0;
      latch_q     <= 1'b0;
      playing_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values computed above.
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      prescaler_q <= prescaler_d;
      dur_q       <= dur_d;
      max_count_q <= max_count_d;
      latch_q     <= latch_d;
      playing_q   <= playing_d;
    end
  end

  assign note_full       = full;
  assign note_count      = count_q;
  assign playing         = playing_q;
  assign max_count       = max_count_q;
  assign latch_max_count = latch_q;

endmodule
